hdlc_rx_reader: RTL and testbench

- Bus-side consumer of the Hdlc core. Attaches to the core's address/read/write register port.
- When the core signals Rx_Ready, the block reads the Rx status register, then the frame length, then drains the Rx buffer.
- Drained bytes are presented as a valid/ready byte stream with a last-byte marker. Bad frames are dropped in the core, and a status pulse plus counters are reported.

---
 rtl/hdlc_rx_reader_if.sv | 27 ++
 rtl/hdlc_rx_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_hdlc_rx_reader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_reader_if.sv
// Core register port plus outgoing byte stream of the HDLC Rx reader.
// master = reader side, slave = core/sink side.
interface hdlc_rx_reader_if;
   logic [2:0] address;
   logic       write_enable;
   logic       read_enable;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;

   modport master (
      output address, write_enable, read_enable, data_in,
      input  data_out,
      output m_data, m_valid, m_last,
      input  m_ready
   );

   modport slave (
      input  address, write_enable, read_enable, data_in,
      output data_out,
      input  m_data, m_valid, m_last,
      output m_ready
   );
endinterface

// File: rtl/hdlc_rx_reader.sv
// Drains received frames from the HDLC core register port into a valid/ready
// byte stream; bad frames are dropped in the core and reported with counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | wait for Rx_Ready, issue Rx_SC read
// ST_RD_SC  | Rx_SC data on bus; error -> drop, else issue Rx_Len read
// ST_RD_LEN | Rx_Len data on bus; bad length -> drop, else load remaining
// ST_FETCH  | issue Rx_Buff read
// ST_CAPT   | Rx_Buff data on bus, register into stream byte
// ST_HOLD   | present byte until accepted
// ST_DROP   | write Drop bit to Rx_SC
// ST_REPORT | one-cycle status pulse, bump counter
// ST_WAIT   | wait for Rx_Ready low so the same frame is not re-read
module hdlc_rx_reader #(
   parameter int MAX_LEN = 126,
   parameter int CNT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_rx_ready,
   hdlc_rx_reader_if.master   io_bus,
   output logic               o_st_valid,
   output logic [2:0]         o_st_code,
   output logic [CNT_W-1:0]   o_frames_ok,
   output logic [CNT_W-1:0]   o_frames_bad
);

   localparam logic [2:0] LP_ADDR_SC   = 3'd2;
   localparam logic [2:0] LP_ADDR_BUFF = 3'd3;
   localparam logic [2:0] LP_ADDR_LEN  = 3'd4;
   localparam logic [7:0] LP_DROP_CMD  = 8'h02;
   localparam logic [8:0] LP_MAX_LEN   = 9'(MAX_LEN);

   localparam logic [2:0] LP_CODE_OK      = 3'd0;
   localparam logic [2:0] LP_CODE_FRM_ERR = 3'd1;
   localparam logic [2:0] LP_CODE_ABORT   = 3'd2;
   localparam logic [2:0] LP_CODE_OVFL    = 3'd3;
   localparam logic [2:0] LP_CODE_BAD_LEN = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_SC,
      ST_RD_LEN,
      ST_FETCH,
      ST_CAPT,
      ST_HOLD,
      ST_DROP,
      ST_REPORT,
      ST_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [2:0]       r_code;
   logic [7:0]       r_remaining;
   logic [7:0]       r_m_data;
   logic             r_m_valid;
   logic             r_m_last;
   logic [CNT_W-1:0] r_frames_ok;
   logic [CNT_W-1:0] r_frames_bad;

   logic [2:0]       w_address;
   logic             w_read_enable;
   logic             w_write_enable;
   logic [7:0]       w_data_in;
   logic             w_st_valid;
   logic [2:0]       w_sc_code;
   logic             w_len_bad;
   logic             w_accept;

   // FrameError outranks Abort, which outranks Overflow
   always_comb begin
      w_sc_code = LP_CODE_OK;
      if (io_bus.data_out[2]) begin
         w_sc_code = LP_CODE_FRM_ERR;
      end else if (io_bus.data_out[3]) begin
         w_sc_code = LP_CODE_ABORT;
      end else if (io_bus.data_out[4]) begin
         w_sc_code = LP_CODE_OVFL;
      end
   end

   assign w_len_bad = (io_bus.data_out == 8'd0) ||
                      ({1'b0, io_bus.data_out} > LP_MAX_LEN);
   assign w_accept  = r_m_valid && io_bus.m_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Bus strobes are decoded from state so read data lands in the following state;
   // the IDLE read is held off while reset is asserted.
   always_comb begin
      w_next         = r_state;
      w_address      = 3'd0;
      w_read_enable  = 1'b0;
      w_write_enable = 1'b0;
      w_data_in      = 8'd0;
      w_st_valid     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_rx_ready && !i_rst) begin
               w_address     = LP_ADDR_SC;
               w_read_enable = 1'b1;
               w_next        = ST_RD_SC;
            end
         end
         ST_RD_SC: begin
            if (w_sc_code != LP_CODE_OK) begin
               w_next = ST_DROP;
            end else begin
               w_address     = LP_ADDR_LEN;
               w_read_enable = 1'b1;
               w_next        = ST_RD_LEN;
            end
         end
         ST_RD_LEN: begin
            w_next = w_len_bad ? ST_DROP : ST_FETCH;
         end
         ST_FETCH: begin
            w_address     = LP_ADDR_BUFF;
            w_read_enable = 1'b1;
            w_next        = ST_CAPT;
         end
         ST_CAPT: begin
            w_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_accept) begin
               w_next = r_m_last ? ST_REPORT : ST_FETCH;
            end
         end
         ST_DROP: begin
            w_address      = LP_ADDR_SC;
            w_data_in      = LP_DROP_CMD;
            w_write_enable = 1'b1;
            w_next         = ST_REPORT;
         end
         ST_REPORT: begin
            w_st_valid = 1'b1;
            w_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (!i_rx_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_code       <= LP_CODE_OK;
         r_remaining  <= 8'd0;
         r_m_data     <= 8'd0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
         r_frames_ok  <= '0;
         r_frames_bad <= '0;
      end else begin
         case (r_state)
            ST_RD_SC: begin
               r_code <= w_sc_code;
            end
            ST_RD_LEN: begin
               if (w_len_bad) begin
                  r_code <= LP_CODE_BAD_LEN;
               end else begin
                  r_remaining <= io_bus.data_out;
               end
            end
            ST_CAPT: begin
               r_m_data  <= io_bus.data_out;
               r_m_valid <= 1'b1;
               r_m_last  <= (r_remaining == 8'd1);
            end
            ST_HOLD: begin
               if (w_accept) begin
                  r_m_valid   <= 1'b0;
                  r_m_last    <= 1'b0;
                  r_remaining <= r_remaining - 8'd1;
               end
            end
            ST_REPORT: begin
               if (r_code == LP_CODE_OK) begin
                  if (r_frames_ok != '1) begin
                     r_frames_ok <= r_frames_ok + CNT_W'(1);
                  end
               end else if (r_frames_bad != '1) begin
                  r_frames_bad <= r_frames_bad + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.address      = w_address;
   assign io_bus.read_enable  = w_read_enable;
   assign io_bus.write_enable = w_write_enable;
   assign io_bus.data_in      = w_data_in;
   assign io_bus.m_data       = r_m_data;
   assign io_bus.m_valid      = r_m_valid;
   assign io_bus.m_last       = r_m_last;

   assign o_st_valid   = w_st_valid;
   assign o_st_code    = r_code;
   assign o_frames_ok  = r_frames_ok;
   assign o_frames_bad = r_frames_bad;

endmodule

// File: tb/tb_hdlc_rx_reader.sv
// Directed bench for hdlc_rx_reader: behavioural core register model, stream
// monitor, and a narrow-counter instance for saturation.
module tb_hdlc_rx_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_ready = 1'b0;
   logic        st_valid;
   logic [2:0]  st_code;
   logic [15:0] frames_ok;
   logic [15:0] frames_bad;

   logic        rx_ready2 = 1'b0;
   logic        st_valid2;
   logic [2:0]  st_code2;
   logic [2:0]  frames_ok2;
   logic [2:0]  frames_bad2;

   hdlc_rx_reader_if bus ();
   hdlc_rx_reader_if bus2 ();

   hdlc_rx_reader #(.MAX_LEN(126), .CNT_W(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_ready   (rx_ready),
      .io_bus       (bus),
      .o_st_valid   (st_valid),
      .o_st_code    (st_code),
      .o_frames_ok  (frames_ok),
      .o_frames_bad (frames_bad)
   );

   hdlc_rx_reader #(.MAX_LEN(126), .CNT_W(3)) dut_sat (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_ready   (rx_ready2),
      .io_bus       (bus2),
      .o_st_valid   (st_valid2),
      .o_st_code    (st_code2),
      .o_frames_ok  (frames_ok2),
      .o_frames_bad (frames_bad2)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          n_bytes, n_status, n_buff_reads, n_len_reads, n_writes, n_both;
   logic [2:0]  last_waddr;
   logic [7:0]  last_wdata;
   logic [2:0]  last_code;
   logic [7:0]  got_data[$];
   bit          got_last[$];
   int          acc_cyc[$];
   logic [2:0]  rd_addr_log[$];

   logic [7:0]  core_sc, core_len;
   logic [7:0]  core_buf[256];
   int          buf_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Core register model: read data appears the cycle after the strobe
   always @(posedge clk) begin
      cyc++;
      if (bus.read_enable) begin
         rd_addr_log.push_back(bus.address);
         case (bus.address)
            3'd2: bus.data_out <= core_sc;
            3'd4: begin bus.data_out <= core_len; n_len_reads++; end
            3'd3: begin
               bus.data_out <= core_buf[buf_idx & 255];
               buf_idx++;
               n_buff_reads++;
            end
            default: bus.data_out <= 8'h00;
         endcase
      end
      if (bus.write_enable) begin
         n_writes++;
         last_waddr = bus.address;
         last_wdata = bus.data_in;
      end
      if (bus.read_enable && bus.write_enable) n_both++;
      if (bus.m_valid && bus.m_ready) begin
         got_data.push_back(bus.m_data);
         got_last.push_back(bus.m_last);
         acc_cyc.push_back(cyc);
         n_bytes++;
      end
      if (st_valid) begin
         n_status++;
         last_code = st_code;
      end
      if (bus2.read_enable) bus2.data_out <= 8'h09;
   end

   task automatic clear_logs();
      n_bytes = 0; n_status = 0; n_buff_reads = 0; n_len_reads = 0; n_writes = 0;
      last_waddr = 3'd0; last_wdata = 8'h00; last_code = 3'd7;
      got_data.delete(); got_last.delete(); acc_cyc.delete(); rd_addr_log.delete();
   endtask

   task automatic do_reset();
      rx_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [7:0] sc, input logic [7:0] len,
                            input int stall_cyc, output int first_valid);
      int stall_left;
      bit done;
      core_sc = sc; core_len = len; buf_idx = 0;
      clear_logs();
      stall_left = stall_cyc; first_valid = -1; done = 0;
      @(negedge clk);
      rx_ready = 1'b1;
      bus.m_ready = 1'b1;
      #1;
      chk("start_re", bus.read_enable, 1);
      chk("start_addr", bus.address, 3'd2);
      for (int c = 0; c < 1000 && !done; c++) begin
         @(negedge clk);
         if (bus.m_valid && first_valid < 0) first_valid = c + 1;
         if (bus.m_valid && n_bytes == 1 && stall_left > 0) begin
            bus.m_ready = 1'b0;
            stall_left--;
            chk("stall_data", bus.m_data, core_buf[1]);
            chk("stall_reads", n_buff_reads, 2);
         end else begin
            bus.m_ready = 1'b1;
         end
         if (n_status > 0) done = 1;
      end
      if (!done) chk("frame_timeout", 0, 1);
      chk("stall_count", stall_cyc - stall_left, stall_cyc);
      rx_ready = 1'b0;
      bus.m_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic sat_frame();
      bit seen;
      seen = 0;
      @(negedge clk);
      rx_ready2 = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (st_valid2) seen = 1;
      end
      if (!seen) chk("sat_timeout", 0, 1);
      chk("sat_code", st_code2, 3'd2);
      rx_ready2 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int fv;
      int errs;
      int nlast;
      bit found;

      bus.m_ready = 1'b1;
      bus2.m_ready = 1'b1;
      clear_logs();
      n_both = 0;
      do_reset();

      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_last", bus.m_last, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_st_valid", st_valid, 0);
      chk("rst_st_code", st_code, 0);
      chk("rst_ok", frames_ok, 0);
      chk("rst_bad", frames_bad, 0);
      chk("rst_addr", bus.address, 0);
      chk("rst_re", bus.read_enable, 0);
      chk("rst_we", bus.write_enable, 0);

      // good three-byte frame, free-running sink
      core_buf[0] = 8'hA5; core_buf[1] = 8'h5A; core_buf[2] = 8'h7E;
      run_frame(8'h01, 8'd3, 0, fv);
      chk("good_nbytes", n_bytes, 3);
      chk("good_b0", got_data.size() > 0 ? got_data[0] : 8'hXX, 8'hA5);
      chk("good_b1", got_data.size() > 1 ? got_data[1] : 8'hXX, 8'h5A);
      chk("good_b2", got_data.size() > 2 ? got_data[2] : 8'hXX, 8'h7E);
      chk("good_last", {got_last.size() > 0 ? got_last[0] : 1'b1,
                        got_last.size() > 1 ? got_last[1] : 1'b1,
                        got_last.size() > 2 ? got_last[2] : 1'b0}, 3'b001);
      chk("good_buff_reads", n_buff_reads, 3);
      chk("good_latency", fv, 5);
      chk("good_rate", acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : 0, 3);
      chk("good_status", n_status, 1);
      chk("good_code", last_code, 0);
      chk("good_ok", frames_ok, 1);
      chk("good_writes", n_writes, 0);

      // same frame, sink stalls four cycles on byte 2
      run_frame(8'h01, 8'd3, 4, fv);
      chk("bp_nbytes", n_bytes, 3);
      chk("bp_b1", got_data.size() > 1 ? got_data[1] : 8'hXX, 8'h5A);
      chk("bp_b2", got_data.size() > 2 ? got_data[2] : 8'hXX, 8'h7E);
      chk("bp_buff_reads", n_buff_reads, 3);
      chk("bp_ok", frames_ok, 2);

      // frame error: drop without Rx_Len read
      run_frame(8'h05, 8'd3, 0, fv);
      chk("fe_len_reads", n_len_reads, 0);
      chk("fe_nbytes", n_bytes, 0);
      chk("fe_writes", n_writes, 1);
      chk("fe_waddr", last_waddr, 3'd2);
      chk("fe_wdata", last_wdata, 8'h02);
      chk("fe_code", last_code, 3'd1);
      chk("fe_bad", frames_bad, 1);

      // Abort beats Overflow; Overflow alone
      run_frame(8'h19, 8'd3, 0, fv);
      chk("ab_code", last_code, 3'd2);
      run_frame(8'h11, 8'd3, 0, fv);
      chk("ov_code", last_code, 3'd3);
      chk("ov_bad", frames_bad, 3);

      // bad lengths
      run_frame(8'h01, 8'd0, 0, fv);
      chk("len0_code", last_code, 3'd4);
      chk("len0_buff_reads", n_buff_reads, 0);
      chk("len0_writes", n_writes, 1);
      run_frame(8'h01, 8'd127, 0, fv);
      chk("len127_code", last_code, 3'd4);
      chk("len127_nbytes", n_bytes, 0);
      chk("len_bad", frames_bad, 5);
      chk("len_ok", frames_ok, 2);

      // longest legal frame
      for (int i = 0; i < 256; i++) core_buf[i] = 8'(i) ^ 8'h3C;
      run_frame(8'h01, 8'd126, 0, fv);
      chk("max_nbytes", n_bytes, 126);
      errs = 0; nlast = 0;
      for (int i = 0; i < got_data.size(); i++) begin
         if (got_data[i] !== (8'(i) ^ 8'h3C)) errs++;
         if (got_last[i]) nlast++;
      end
      chk("max_data", errs, 0);
      chk("max_nlast", nlast, 1);
      chk("max_last_pos", got_last.size() == 126 ? got_last[125] : 1'b0, 1);
      chk("max_code", last_code, 0);
      chk("max_ok", frames_ok, 3);

      // reset while holding byte 2
      core_buf[0] = 8'hA5; core_buf[1] = 8'h5A; core_buf[2] = 8'h7E;
      core_sc = 8'h01; core_len = 8'd3; buf_idx = 0;
      clear_logs();
      @(negedge clk);
      rx_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         if (bus.m_valid && n_bytes == 1) begin
            bus.m_ready = 1'b0;
            found = 1;
         end
      end
      chk("hold_reached", found, 1);
      rst = 1'b1;
      #1;
      chk("mid_m_valid", bus.m_valid, 0);
      chk("mid_m_data", bus.m_data, 0);
      chk("mid_m_last", bus.m_last, 0);
      chk("mid_ok", frames_ok, 0);
      chk("mid_bad", frames_bad, 0);
      chk("mid_st_valid", st_valid, 0);
      chk("mid_re", bus.read_enable, 0);
      chk("mid_addr", bus.address, 0);
      repeat (2) @(negedge clk);
      clear_logs();
      bus.m_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_restart_rd", rd_addr_log.size() > 0 ? rd_addr_log[0] : 3'd7, 3'd2);
      chk("mid_no_status", n_status, 0);
      do_reset();

      // narrow counters saturate
      for (int i = 0; i < 7; i++) sat_frame();
      chk("sat_bad7", frames_bad2, 3'd7);
      for (int i = 0; i < 2; i++) sat_frame();
      chk("sat_bad_hold", frames_bad2, 3'd7);
      chk("sat_ok", frames_ok2, 3'd0);

      chk("one_strobe", n_both, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
